// File: rtl/alu_control_pkg.sv
// rtl/alu_control_pkg.sv - ALUOp, function, ALU operation and FSM codes for alu_control_pipe
package alu_control_pkg;

    localparam logic [2:0] ALUOP_MEM    = 3'b001;
    localparam logic [2:0] ALUOP_BRANCH = 3'b010;
    localparam logic [2:0] ALUOP_LUI    = 3'b011;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_ORI    = 3'b101;
    localparam logic [2:0] ALUOP_ANDI   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_NONE  = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_PASSB = 4'b1011;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b01;
    localparam logic [1:0] HILO_LO   = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic [3:0] op;
        logic       shamt;
        logic       jr;
        logic [1:0] hilo;
        logic       muldiv;
        logic       md_div;
        logic       md_signed;
    } dec_t;

endpackage

// File: rtl/alu_control_decode.sv
// rtl/alu_control_decode.sv - combinational ALUOp/function selector for alu_control_pipe
module alu_control_decode
    import alu_control_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3
) (
    input  logic [ALUOP_WIDTH-1:0] i_alu_op,
    input  logic [5:0]             i_funct,
    output dec_t                   o_dec
);

    always_comb begin
        o_dec    = '0;
        o_dec.op = OP_NONE;
        if (i_alu_op == ALUOP_WIDTH'(ALUOP_RTYPE)) begin
            case (i_funct)
                FN_AND:           o_dec.op = OP_AND;
                FN_OR:            o_dec.op = OP_OR;
                FN_NOR:           o_dec.op = OP_NOR;
                FN_ADD, FN_ADDU:  o_dec.op = OP_ADD;
                FN_SUB, FN_SUBU:  o_dec.op = OP_SUB;
                FN_XOR:           o_dec.op = OP_XOR;
                FN_SLT:           o_dec.op = OP_SLT;
                FN_SLL: begin
                    o_dec.op    = OP_SLL;
                    o_dec.shamt = 1'b1;
                end
                FN_SRL: begin
                    o_dec.op    = OP_SRL;
                    o_dec.shamt = 1'b1;
                end
                FN_JR:            o_dec.jr = 1'b1;
                FN_MFHI: begin
                    o_dec.op   = OP_PASSB;
                    o_dec.hilo = HILO_HI;
                end
                FN_MFLO: begin
                    o_dec.op   = OP_PASSB;
                    o_dec.hilo = HILO_LO;
                end
                // funct[1] selects divide, funct[0] selects the unsigned form
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                    o_dec.muldiv    = 1'b1;
                    o_dec.md_div    = i_funct[1];
                    o_dec.md_signed = ~i_funct[0];
                end
                default: ;
            endcase
        end else begin
            case (i_alu_op)
                ALUOP_WIDTH'(ALUOP_ADDI):   o_dec.op = OP_ADD;
                ALUOP_WIDTH'(ALUOP_ORI):    o_dec.op = OP_OR;
                ALUOP_WIDTH'(ALUOP_ANDI):   o_dec.op = OP_AND;
                ALUOP_WIDTH'(ALUOP_MEM):    o_dec.op = OP_ADD;
                ALUOP_WIDTH'(ALUOP_BRANCH): o_dec.op = OP_SUB;
                ALUOP_WIDTH'(ALUOP_LUI):    o_dec.op = OP_LUI;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - ID/EX ALU control register with mult/div sequencer; ALUCTRL_ILLEGAL_EN adds sticky illegal flag
module alu_control_pipe
    import alu_control_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int OP_WIDTH    = 4,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ALUOP_WIDTH-1:0] alu_op_i,
    input  logic [5:0]             alu_function_i,
    input  logic                   id_valid_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [OP_WIDTH-1:0]    alu_operation_o,
    output logic                   ex_valid_o,
    output logic                   shamt_sel_o,
    output logic                   jr_o,
    output logic [1:0]             hilo_sel_o,
    output logic                   muldiv_start_o,
    output logic                   muldiv_div_o,
    output logic                   muldiv_signed_o,
    output logic                   muldiv_busy_o,
    output logic                   muldiv_done_o,
    output logic                   illegal_op_o
);

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    dec_t                w_dec;
    logic                w_accept;
    logic                w_start;
    logic                w_hilo_dep;
    logic [0:0]          r_state;
    logic [7:0]          r_count;
    logic [OP_WIDTH-1:0] r_op;
    logic                r_valid, r_shamt, r_jr, r_start, r_div, r_signed, r_done;
    logic [1:0]          r_hilo;

    alu_control_decode #(.ALUOP_WIDTH(ALUOP_WIDTH)) u_decode (
        .i_alu_op (alu_op_i),
        .i_funct  (alu_function_i),
        .o_dec    (w_dec)
    );

    // Only instructions touching the mult/div unit or HI/LO wait on the sequencer
    assign w_hilo_dep = w_dec.muldiv | (w_dec.hilo != HILO_NONE);
    assign stall_o    = muldiv_busy_o & id_valid_i & w_hilo_dep;
    assign w_accept   = id_valid_i & ~stall_o & ~flush_i;
    assign w_start    = w_accept & w_dec.muldiv;

    always_ff @(posedge clk) begin
        if (reset || !w_accept) begin
            r_op    <= OP_WIDTH'(OP_NONE);
            r_valid <= 1'b0;
            r_shamt <= 1'b0;
            r_jr    <= 1'b0;
            r_hilo  <= HILO_NONE;
        end else begin
            r_op    <= OP_WIDTH'(w_dec.op);
            r_valid <= 1'b1;
            r_shamt <= w_dec.shamt;
            r_jr    <= w_dec.jr;
            r_hilo  <= w_dec.hilo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'd0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_div    <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            r_start <= w_start;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_BUSY;
                        r_count  <= w_dec.md_div ? DIV_LOAD : MUL_LOAD;
                        r_div    <= w_dec.md_div;
                        r_signed <= w_dec.md_signed;
                    end
                end
                ST_BUSY: begin
                    if (r_count == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef ALUCTRL_ILLEGAL_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
        if (reset)
            r_illegal <= 1'b0;
        else if (w_accept && w_dec.op == OP_NONE && !w_dec.jr && !w_dec.muldiv)
            r_illegal <= 1'b1;
    end
    assign illegal_op_o = r_illegal;
`else
    assign illegal_op_o = 1'b0;
`endif

    assign alu_operation_o = r_op;
    assign ex_valid_o      = r_valid;
    assign shamt_sel_o     = r_shamt;
    assign jr_o            = r_jr;
    assign hilo_sel_o      = r_hilo;
    assign muldiv_start_o  = r_start;
    assign muldiv_div_o    = r_div;
    assign muldiv_signed_o = r_signed;
    assign muldiv_busy_o   = (r_state == ST_BUSY);
    assign muldiv_done_o   = r_done;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - randomized and directed checks of alu_control_pipe against a cycle-indexed model
module tb_alu_control_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alu_op_i;
    logic [5:0] alu_function_i;
    logic       id_valid_i, flush_i;
    logic       stall_o;
    logic [3:0] alu_operation_o;
    logic       ex_valid_o, shamt_sel_o, jr_o;
    logic [1:0] hilo_sel_o;
    logic       muldiv_start_o, muldiv_div_o, muldiv_signed_o, muldiv_busy_o, muldiv_done_o;
    logic       illegal_op_o;

    alu_control_pipe #(.ALUOP_WIDTH(3), .OP_WIDTH(4), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_op_i        (alu_op_i),
        .alu_function_i  (alu_function_i),
        .id_valid_i      (id_valid_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .alu_operation_o (alu_operation_o),
        .ex_valid_o      (ex_valid_o),
        .shamt_sel_o     (shamt_sel_o),
        .jr_o            (jr_o),
        .hilo_sel_o      (hilo_sel_o),
        .muldiv_start_o  (muldiv_start_o),
        .muldiv_div_o    (muldiv_div_o),
        .muldiv_signed_o (muldiv_signed_o),
        .muldiv_busy_o   (muldiv_busy_o),
        .muldiv_done_o   (muldiv_done_o),
        .illegal_op_o    (illegal_op_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       sh;
        logic       jr;
        logic [1:0] hl;
        logic       md;
        logic       dv;
        logic       sg;
        logic       ill;
    } ref_t;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    // sequencer modelled by time: start visible at cycle sc, busy sc..sc+sn-1, done at sc+sn
    int   sc    = -1000;
    int   sn    = 1;
    logic m_div = 1'b0, m_sgn = 1'b0, m_ill = 1'b0;

    function automatic ref_t ref_decode(input logic [2:0] aop, input logic [5:0] fn);
        ref_t r;
        r    = '0;
        r.op = 4'd9;
        if (aop == 3'd7) begin
            case (fn)
                6'h24:        r.op = 4'd0;
                6'h25:        r.op = 4'd1;
                6'h27:        r.op = 4'd2;
                6'h20, 6'h21: r.op = 4'd3;
                6'h22, 6'h23: r.op = 4'd4;
                6'h26:        r.op = 4'd5;
                6'h2A:        r.op = 4'd6;
                6'h00: begin r.op = 4'd7; r.sh = 1'b1; end
                6'h02: begin r.op = 4'd8; r.sh = 1'b1; end
                6'h08:        r.jr = 1'b1;
                6'h10: begin r.op = 4'd11; r.hl = 2'b01; end
                6'h12: begin r.op = 4'd11; r.hl = 2'b10; end
                6'h18: begin r.md = 1'b1; r.sg = 1'b1; end
                6'h19:        r.md = 1'b1;
                6'h1A: begin r.md = 1'b1; r.dv = 1'b1; r.sg = 1'b1; end
                6'h1B: begin r.md = 1'b1; r.dv = 1'b1; end
                default:      r.ill = 1'b1;
            endcase
        end else begin
            case (aop)
                3'd4:    r.op = 4'd3;
                3'd5:    r.op = 4'd1;
                3'd6:    r.op = 4'd0;
                3'd1:    r.op = 4'd3;
                3'd2:    r.op = 4'd4;
                3'd3:    r.op = 4'd10;
                default: r.ill = 1'b1;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic fl,
                        input logic [2:0] aop, input logic [5:0] fn);
        ref_t d;
        logic e_stall, acc;
        reset          = rst;
        id_valid_i     = v;
        flush_i        = fl;
        alu_op_i       = aop;
        alu_function_i = fn;
        d       = ref_decode(aop, fn);
        e_stall = (cyc >= sc) && (cyc < sc + sn) && v && (d.md || d.hl != 2'b00);
        acc     = v && !e_stall && !fl;
        @(negedge clk);
        if (!rst) chk("stall", stall_o, e_stall);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sc = -1000; m_div = 1'b0; m_sgn = 1'b0; m_ill = 1'b0;
            acc = 1'b0;
        end else begin
            if (acc && d.md) begin
                sc = cyc; sn = d.dv ? 32 : 4; m_div = d.dv; m_sgn = d.sg;
            end
`ifdef ALUCTRL_ILLEGAL_EN
            if (acc && d.ill) m_ill = 1'b1;
`endif
        end
        chk("op",     alu_operation_o, acc ? d.op : 4'd9);
        chk("valid",  ex_valid_o,      acc);
        chk("shamt",  shamt_sel_o,     acc & d.sh);
        chk("jr",     jr_o,            acc & d.jr);
        chk("hilo",   hilo_sel_o,      acc ? d.hl : 2'b00);
        chk("start",  muldiv_start_o,  cyc == sc);
        chk("busy",   muldiv_busy_o,   (cyc >= sc) && (cyc < sc + sn));
        chk("done",   muldiv_done_o,   cyc == sc + sn);
        chk("div",    muldiv_div_o,    m_div);
        chk("signed", muldiv_signed_o, m_sgn);
        chk("illegal", illegal_op_o,   m_ill);
    endtask

    logic [5:0] fn_tab [18] = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h26, 6'h2A,
                                6'h00, 6'h02, 6'h08, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [5:0] rt_tab [6]  = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h2A};

    initial begin
        step(1, 0, 0, 3'd0, 6'h00);
        step(1, 0, 0, 3'd0, 6'h00);
        foreach (rt_tab[i]) step(0, 1, 0, 3'd7, rt_tab[i]);
        step(0, 1, 0, 3'd4, 6'h3F);
        step(0, 1, 0, 3'd5, 6'h3F);
        step(0, 1, 0, 3'd3, 6'h3F);
        step(0, 1, 0, 3'd7, 6'h3F);
        step(0, 0, 0, 3'd0, 6'h00);
        // MULT then MFLO waiting through the busy window
        step(0, 1, 0, 3'd7, 6'h18);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 3'd7, 6'h12);
        step(0, 0, 0, 3'd0, 6'h00);
        // DIVU then a MULT held until it issues in the done cycle
        step(0, 1, 0, 3'd7, 6'h1B);
        for (int i = 0; i < 33; i++) step(0, 1, 0, 3'd7, 6'h18);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 3'd0, 6'h00);
        // stall and flush together
        step(0, 1, 0, 3'd7, 6'h19);
        step(0, 1, 1, 3'd7, 6'h10);
        step(0, 1, 1, 3'd7, 6'h10);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 6'h00);
        // reset mid-DIV at count 10
        step(0, 1, 0, 3'd7, 6'h1A);
        for (int i = 0; i < 21; i++) step(0, 0, 0, 3'd0, 6'h00);
        step(1, 1, 0, 3'd7, 6'h24);
        for (int i = 0; i < 36; i++) step(0, 0, 0, 3'd0, 6'h00);
        for (int i = 0; i < 600; i++) begin
            logic [5:0] fn;
            logic [2:0] aop;
            fn  = ($urandom_range(0, 9) < 8) ? fn_tab[$urandom_range(0, 17)] : 6'($urandom);
            aop = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd7;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) == 0, aop, fn);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
